// File: rtl/nrs_ls_estimator_if.sv
// Streaming port bundle of the NRS least-squares estimator: beat input,
// per-beat estimate output and the estimate-buffer read port.
interface nrs_ls_estimator_if #(
    parameter int unsigned WIDTH_R_I = 16,
    parameter int unsigned ADDR_W    = 3
);
    logic                        start;
    logic                        avg_mode;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH_R_I-1:0] rx_r;
    logic signed [WIDTH_R_I-1:0] rx_i;
    logic                        nrs_r;
    logic                        nrs_i;
    logic                        out_valid;
    logic signed [WIDTH_R_I:0]   out_r;
    logic signed [WIDTH_R_I:0]   out_i;
    logic        [ADDR_W-1:0]    rd_addr;
    logic signed [WIDTH_R_I:0]   est_r;
    logic signed [WIDTH_R_I:0]   est_i;
    logic                        full;

    modport slave (
        input  start, avg_mode, in_valid, rx_r, rx_i, nrs_r, nrs_i, rd_addr,
        output in_ready, out_valid, out_r, out_i, est_r, est_i, full
    );

    modport master (
        output start, avg_mode, in_valid, rx_r, rx_i, nrs_r, nrs_i, rd_addr,
        input  in_ready, out_valid, out_r, out_i, est_r, est_i, full
    );
endinterface

// File: rtl/nrs_ls_estimator.sv
// Least-squares NRS channel estimator: multiplies each received RE by the
// conjugate of its QPSK pilot, streams the estimate out and stores it in a
// DEPTH-entry buffer, optionally averaging two passes over the buffer.
module nrs_ls_estimator #(
    parameter int unsigned        WIDTH_R_I        = 16,
    parameter int unsigned        PILOT_FLOAT_BITS = 11,
    parameter logic signed [11:0] PILOT_MAG        = 12'sb0101_1010_1000,
    parameter int unsigned        DEPTH            = 8,
    parameter int unsigned        ADDR_W           = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    nrs_ls_estimator_if.slave bus
);
    localparam int unsigned PilotW = 12;
    localparam int unsigned ProdW  = WIDTH_R_I + PilotW;
    localparam int unsigned LongW  = WIDTH_R_I + PILOT_FLOAT_BITS + 1;
    localparam int unsigned EstW   = WIDTH_R_I + 1;
    localparam int unsigned SumW   = WIDTH_R_I + 2;

    typedef enum logic [2:0] {StIdle, StFill, StAvg, StDrain, StDone} state_e;

    state_e                  r_state;
    logic                    r_avg;
    logic                    r_pass;
    logic                    r_full;
    logic [ADDR_W-1:0]       r_ptr;

    logic                    r_s1_valid;
    logic                    r_s1_pass;
    logic                    r_s1_last;
    logic [ADDR_W-1:0]       r_s1_addr;
    logic signed [ProdW-1:0] r_rr, r_ii, r_ir, r_ri;

    logic                    r_out_valid;
    logic signed [EstW-1:0]  r_out_r, r_out_i;
    logic signed [EstW-1:0]  r_mem_r [DEPTH];
    logic signed [EstW-1:0]  r_mem_i [DEPTH];

    logic signed [PilotW-1:0] w_p_r, w_p_i;
    logic                     w_in_ready, w_accept, w_last_ptr, w_run_last;
    logic signed [LongW-1:0]  w_real_long, w_imag_long;
    logic signed [EstW-1:0]   w_est_r, w_est_i;
    logic signed [SumW-1:0]   w_sum_r, w_sum_i;
    logic signed [EstW-1:0]   w_wr_r, w_wr_i;

    assign w_p_r      = bus.nrs_r ? -PILOT_MAG : PILOT_MAG;
    assign w_p_i      = bus.nrs_i ? -PILOT_MAG : PILOT_MAG;
    assign w_in_ready = ((r_state == StFill) || (r_state == StAvg)) && !bus.start;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last_ptr = (r_ptr == ADDR_W'(DEPTH - 1));
    // Final beat of the run: end of pass 1, or end of pass 0 when not averaging.
    assign w_run_last = w_last_ptr && ((r_state == StAvg) || !r_avg);

    // Conjugate products summed at full precision; floor via arithmetic shift.
    assign w_real_long = LongW'(r_rr) + LongW'(r_ii);
    assign w_imag_long = LongW'(r_ir) - LongW'(r_ri);
    assign w_est_r     = EstW'(w_real_long >>> PILOT_FLOAT_BITS);
    assign w_est_i     = EstW'(w_imag_long >>> PILOT_FLOAT_BITS);
    assign w_sum_r     = SumW'(r_mem_r[r_s1_addr]) + SumW'(w_est_r);
    assign w_sum_i     = SumW'(r_mem_i[r_s1_addr]) + SumW'(w_est_i);
    assign w_wr_r      = r_s1_pass ? EstW'(w_sum_r >>> 1) : w_est_r;
    assign w_wr_i      = r_s1_pass ? EstW'(w_sum_i >>> 1) : w_est_i;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_out_r;
    assign bus.out_i     = r_out_i;
    assign bus.full      = r_full;
    assign bus.est_r     = r_mem_r[bus.rd_addr];
    assign bus.est_i     = r_mem_i[bus.rd_addr];

    // Run control: state, accept pointer, pass, latched mode and full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_avg   <= 1'b0;
            r_pass  <= 1'b0;
            r_ptr   <= '0;
            r_full  <= 1'b0;
        end else if (bus.start) begin
            r_state <= StFill;
            r_avg   <= bus.avg_mode;
            r_pass  <= 1'b0;
            r_ptr   <= '0;
            r_full  <= 1'b0;
        end else begin
            r_full <= (r_state == StDone);
            if (w_accept) begin
                if (w_last_ptr) begin
                    r_ptr <= '0;
                    if ((r_state == StFill) && r_avg) begin
                        r_pass  <= 1'b1;
                        r_state <= StAvg;
                    end else begin
                        r_state <= StDrain;
                    end
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
            if ((r_state == StDrain) && r_s1_valid && r_s1_last) begin
                r_state <= StDone;
            end
        end
    end

    // Stage 1: register the four pilot products with the beat's buffer tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pass  <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
            r_rr       <= '0;
            r_ii       <= '0;
            r_ir       <= '0;
            r_ri       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pass <= r_pass;
                r_s1_last <= w_run_last;
                r_s1_addr <= r_ptr;
                r_rr      <= ProdW'(bus.rx_r) * ProdW'(w_p_r);
                r_ii      <= ProdW'(bus.rx_i) * ProdW'(w_p_i);
                r_ir      <= ProdW'(bus.rx_i) * ProdW'(w_p_r);
                r_ri      <= ProdW'(bus.rx_r) * ProdW'(w_p_i);
            end
        end
    end

    // Stage 2: present the per-beat estimate and commit it to the buffer;
    // a start in the same cycle drops the beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem_r[k] <= '0;
                r_mem_i[k] <= '0;
            end
        end else begin
            r_out_valid <= r_s1_valid && !bus.start;
            if (r_s1_valid && !bus.start) begin
                r_out_r              <= w_est_r;
                r_out_i              <= w_est_i;
                r_mem_r[r_s1_addr]   <= w_wr_r;
                r_mem_i[r_s1_addr]   <= w_wr_i;
            end
        end
    end
endmodule

// File: doc/nrs_ls_estimator.md
Name: nrs_ls_estimator

Overview:
Pipelined least-squares channel estimator for NB-IoT NRS resource elements. Each received RE is multiplied by the conjugate of its QPSK pilot (±1/√2 ± j/√2) and the result is written into a DEPTH-entry estimate buffer. An optional two-pass mode averages estimates across two NRS symbols. It sits between the RE demapper and the channel interpolator, and is the parametrised, streaming successor of the fixed 4-entry de-rotator.

Parameters:
WIDTH_R_I, 16, signed width of rx_r and rx_i.
PILOT_FLOAT_BITS, 11, fractional bits of the pilot magnitude.
PILOT_MAG, 12'sb0_1011010_1000 (+1448), pilot magnitude ≈ 1/√2; its negative is -1448.
DEPTH, 8, number of estimate buffer entries (≥2).
ADDR_W, 3, clog2(DEPTH).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a new estimation run
avg_mode  in  1  sampled on start; 1 selects two-pass averaging
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
rx_r, rx_i  in  WIDTH_R_I  signed received RE
nrs_r, nrs_i  in  1  pilot sign bits (1 = negative component)
out_valid  out  1  per-beat estimate valid
out_r, out_i  out  WIDTH_R_I+1  per-beat signed estimate (never averaged)
rd_addr  in  ADDR_W  buffer read address
est_r, est_i  out  WIDTH_R_I+1  combinational read of the buffer at rd_addr
full  out  1  run complete; buffer stable

Behaviour:
- Reset (rst low, async): all buffer entries 0; state IDLE; in_ready, out_valid and full 0; out_r and out_i 0; both pipeline stages invalid.
- Pilot: p_r = nrs_r ? -PILOT_MAG : +PILOT_MAG; p_i is the same using nrs_i.
- Arithmetic (bit-exact):
  - real_long = rx_r*p_r + rx_i*p_i
  - imag_long = rx_i*p_r - rx_r*p_i
  - real_long and imag_long are WIDTH_R_I+PILOT_FLOAT_BITS+1 bits.
  - Each result is bits [WIDTH_R_I+PILOT_FLOAT_BITS : PILOT_FLOAT_BITS], i.e. an arithmetic shift with floor. No rounding, no saturation; 17 bits always suffice.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready = (state is FILL or AVG) && !start && the accept counter has not yet taken the final beat of the run.
- Pipeline, 2 cycles:
  - Stage 1 registers the four products and the beat's address/pass tag.
  - Stage 2 forms the sums, drives out_r/out_i with out_valid=1 for one cycle, and commits the buffer write.
  - Latency from acceptance to out_valid is 2 cycles. Throughput is 1 beat/cycle with no bubbles.
- Buffer write:
  - Pass 0: mem[a] = estimate.
  - Pass 1: mem[a] = (mem[a] + estimate) >>> 1, using a WIDTH_R_I+2-bit intermediate, floor.
- Address: the input-side accept pointer runs 0..DEPTH-1. On the final accepted beat of pass 0 with avg_mode=1, the pointer wraps to 0 and the pass becomes 1.
- State machine:
  - IDLE --start--> FILL; avg_mode is latched at this point.
  - FILL --last pass-0 beat accepted, avg=1--> AVG.
  - FILL --last beat accepted, avg=0--> DRAIN.
  - AVG --last pass-1 beat accepted--> DRAIN.
  - DRAIN --final stage-2 write commits--> DONE; full=1 from the cycle after that write.
  - DONE --start--> FILL.
- start in any state:
  - Flushes both pipeline stages; in-flight beats are not written and produce no out_valid.
  - Pointer and pass reset to 0; full clears the next cycle.
  - A beat presented in the start cycle is not accepted.
  - Buffer contents are not cleared; pass 0 overwrites them.
- est_r/est_i are readable at all times. During a run they reflect writes already committed.
- Reset mid-run: the block returns to IDLE immediately and the buffer clears to 0.

Test Plan:
- Reset, then start with avg_mode=0; rx=(1000,0), nrs=(0,0) → 2 cycles later out=(707,-708); the same with nrs=(1,1) → (-708,707).
- Full-scale case: rx=(-32768,-32768), nrs=(1,1) → real=46336, imag=0, no overflow.
- avg_mode=0: 8 back-to-back beats → in_ready drops after the 8th; full=1 exactly 3 cycles after the 8th acceptance; est at addresses 0..7 matches the per-beat outputs.
- avg_mode=1: pass 0 uses rx=(1000,0) and pass 1 uses rx=(2000,0), nrs=(0,0) for all beats → every est_r=1060; full asserts only after 16 beats.
- start pulsed while 2 beats are in the pipeline → no out_valid for those beats and the buffer is unchanged at their addresses; the new run begins writing at address 0.
- in_valid toggled randomly with bubbles → writes land in address order; full timing is relative to the last acceptance; rst pulsed mid-run → all est reads 0 and full=0.
